// File: rtl/decoder_nx2n_seq.sv
// Purpose: registered N-to-2^N one-hot decoder with a valid strobe and an autonomous sweep mode.
// Latency: 1 cycle from an accepted request to y/out_valid; a sweep ends NOUT*D cycles after its first line.
// Backpressure: none; requests arriving while busy=1 are dropped, never queued.
// Optional feature: define DECODER_PARITY_EN to add sel_par/par_err even-parity checking on requests.
module decoder_nx2n_seq #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8,
  localparam int NOUT   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_PARITY_EN
  input  logic               sel_par,
  output logic               par_err,
`endif
  output logic [NOUT-1:0]    y,
  output logic               out_valid,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1
  } state_t;

  localparam logic [NOUT-1:0] LINE0 = NOUT'(1);

  state_t             state_q, state_d;
  logic [NOUT-1:0]    y_q, y_d;
  logic               ov_q, ov_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   lines_q, lines_d;   // lines already advanced past in this sweep
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d; // D-1, captured at sweep start
  logic [SEL_W-1:0]   idx_next;
  logic [DWELL_W-1:0] dwell_m1;
  logic               par_ok;

`ifdef DECODER_PARITY_EN
  // Even parity across the select and its parity bit.
  assign par_ok  = ~(^{sel, sel_par});
  assign par_err = perr_q;
`else
  assign par_ok  = 1'b1;
`endif

  assign idx_next  = idx_q + 1'b1;
  assign dwell_m1  = (dwell == '0) ? '0 : dwell - 1'b1;

  assign y          = y_q;
  assign out_valid  = ov_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

  // Next-state and output decode; pulses default low, y holds unless changed.
  always_comb begin
    state_d  = S_IDLE;
    y_d      = y_q;
    ov_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    idx_d    = idx_q;
    lines_d  = lines_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;

    if (!en) begin
      y_d      = '0;
      idx_d    = '0;
      lines_d  = '0;
      cnt_d    = '0;
      reload_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!par_ok) begin
              perr_d = 1'b1;
            end else if (mode) begin
              state_d  = S_SWEEP;
              busy_d   = 1'b1;
              idx_d    = sel;
              lines_d  = '0;
              reload_d = dwell_m1;
              cnt_d    = dwell_m1;
              y_d      = LINE0 << sel;
              ov_d     = 1'b1;
            end else begin
              y_d  = LINE0 << sel;
              ov_d = 1'b1;
            end
          end
        end
        S_SWEEP: begin
          state_d = S_SWEEP;
          busy_d  = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (lines_q != '1) begin
            idx_d   = idx_next;
            lines_d = lines_q + 1'b1;
            cnt_d   = reload_q;
            y_d     = LINE0 << idx_next;
            ov_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            y_d     = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          y_d     = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      idx_q    <= '0;
      lines_q  <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      ov_q     <= ov_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      idx_q    <= idx_d;
      lines_q  <= lines_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule
